ctr_reg_arb: RTL and testbench
==============================

Name: ctr_reg_arb

Overview:
- Two-requester arbiter and sequencer in front of the ctr1/ctr2 counter-configuration register block.
- Requester 0 is the scan/test host and requester 1 is the functional core. Each requester issues single-word write or read transactions.
- The block grants requesters round-robin, drives the register block's ctr_wen/ctr_ren strobes, waits for the ctr_ready handshake on reads, and returns data, ack and err to the winning requester.

Parameters:
- TIMEOUT, 4, max cycles spent in RWAIT for ctr_ready before aborting the read with err.
- TO_W, 3, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0  input  1  requester 0 transaction request; held until ack0.
- we0  input  1  requester 0 direction: 1=write, 0=read; stable while req0=1.
- wdata0  input  32  requester 0 write data: [16:0]=ctr1, [31:17]=ctr2; stable while req0=1.
- ack0  output  1  one-cycle completion pulse to requester 0.
- err0  output  1  read timeout flag; valid with ack0 only.
- rdata0  output  32  read data in the same packing as wdata0; valid with ack0 only, 0 otherwise.
- req1, we1, wdata1, ack1, err1, rdata1: identical set for requester 1.
- ctr_wen  output  1  write strobe to the register block.
- ctr_ren  output  1  read strobe to the register block.
- ctr1_wdata  output  17  write data for ctr1.
- ctr2_wdata  output  15  write data for ctr2.
- ctr1_rdata  input  17  ctr1 read data from the register block.
- ctr2_rdata  input  15  ctr2 read data from the register block.
- ctr_ready  input  1  read-complete handshake from the register block.
- busy  output  1  high in every state except IDLE.

Behaviour:
- States are IDLE, WR, RD, RWAIT and DONE. All outputs derive from registered state and registered latches.
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; owner=0, last=1 (requester 0 wins the first tie); timeout counter=0.
  - Captured data and all outputs are 0: ack0, ack1, err0, err1, rdata0, rdata1, ctr_wen, ctr_ren, ctr1_wdata, ctr2_wdata, busy.
- IDLE (requests sampled here only):
  - If only one req is high, that requester wins.
  - If both are high, the requester other than "last" wins.
  - The block latches owner, we and wdata, then moves to WR if we=1, else RD.
  - If no req is high, it stays in IDLE.
- WR:
  - ctr_wen=1 for exactly one cycle, with ctr1_wdata/ctr2_wdata = latched wdata.
  - Next state is DONE.
  - ctr1_wdata/ctr2_wdata hold their last value outside WR; they have no meaning when ctr_wen=0.
- RD: ctr_ren=1 for exactly one cycle; next state is RWAIT; timeout counter cleared.
- RWAIT (ctr_wen=ctr_ren=0):
  - If ctr_ready=1, capture {ctr2_rdata, ctr1_rdata} and go to DONE with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to DONE with err=1 and captured data=0.
  - With a conforming register block, ready arrives in the first RWAIT cycle.
- DONE:
  - ack<owner>=1 for one cycle. rdata<owner> = captured data (0 for writes). err<owner> = captured err (0 for writes).
  - The non-owner's ack, err and rdata stay 0.
  - last := owner; next state is IDLE.
- Latency, with req sampled in IDLE at cycle 0:
  - Write: ctr_wen at cycle 1, ack at cycle 2.
  - Read: ctr_ren at cycle 1, capture at cycle 2, ack+rdata at cycle 3.
  - Minimum gap between back-to-back transactions is one IDLE cycle.
- Requester rules:
  - A requester must drop req the cycle after ack. A req still high in IDLE starts a new transaction.
  - Round-robin prevents starvation: with both reqs held continuously, grants alternate 0,1,0,1...
  - req changes outside IDLE are ignored. Dropping req mid-transaction does not abort it; the ack is still issued.
- Reset mid-transaction: the transaction is abandoned with no ack; the requester must reissue. An in-flight ctr_wen/ctr_ren is deasserted in the cycle after reset is sampled.
- Widths: ctr1 maps to bits [16:0] and ctr2 to bits [31:17], with no truncation or extension.

Test Plan:
- Reset then write from req0 (we0=1, wdata0=32'hABCD_1234): ctr_wen=1 at cycle 1 with ctr1_wdata=17'h1_1234 and ctr2_wdata=15'h55E6. ack0=1 at cycle 2 with rdata0=0 and err0=0; ack1 stays 0.
- Read from req1 after the previous write (register model answers ready one cycle after ren): ctr_ren=1 at cycle 1; ack1=1 at cycle 3 with rdata1=32'hABCD_1234 and err1=0.
- Both requesters read with reqs held continuously from reset: grant order is 0,1,0,1; each ack is one cycle; acks never overlap; busy drops for exactly one cycle between transactions.
- Read with ctr_ready tied low, TIMEOUT=4: busy lasts 1 RD cycle + 4 RWAIT cycles + 1 DONE cycle; ack0=1 with err0=1 and rdata0=0; state then returns to IDLE.
- rst=1 asserted during RWAIT: next cycle all outputs are 0 and no ack is issued. A following req1 wins ahead of a simultaneous req0 only if last=0; after reset, req0 wins the first tie.
- Write, then read, from the same requester (wdata0=32'h0001_FFFF): read returns 32'h0001_FFFF, confirming ctr1 = 17'h1_FFFF, ctr2 = 15'h0000 and the packing.

Source files
------------

// File: rtl/ctr_reg_arb.sv
`default_nettype none
// ============================================================================
// Module   : ctr_reg_arb
// Purpose  : Two-requester round-robin arbiter and sequencer in front of the
//            ctr1/ctr2 counter-configuration register block. Requester 0 is
//            the scan/test host, requester 1 the functional core. Each
//            granted single-word write or read is turned into a one-cycle
//            ctr_wen/ctr_ren strobe; reads wait for ctr_ready (bounded by
//            TIMEOUT cycles) and the result is returned with a one-cycle ack.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT     cycles allowed in RWAIT before a read is aborted with err
//   TO_W        timeout counter width, 2**TO_W must exceed TIMEOUT
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   req0/we0/wdata0        requester 0 request, direction (1=write), data
//   ack0/err0/rdata0       requester 0 completion pulse, timeout flag, data
//   req1/we1/wdata1        requester 1 request, direction, data
//   ack1/err1/rdata1       requester 1 completion pulse, timeout flag, data
//   ctr_wen, ctr_ren       write / read strobes to the register block
//   ctr1_wdata/ctr2_wdata  write data for ctr1 (word [16:0]) / ctr2 ([31:17])
//   ctr1_rdata/ctr2_rdata  read data from the register block
//   ctr_ready              read-complete handshake from the register block
//   busy                   high whenever a transaction is in progress
// ============================================================================
module ctr_reg_arb #(
   parameter int TIMEOUT = 4,
   parameter int TO_W    = 3
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] wdata0,
   output logic        ack0,
   output logic        err0,
   output logic [31:0] rdata0,

   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] wdata1,
   output logic        ack1,
   output logic        err1,
   output logic [31:0] rdata1,

   output logic        ctr_wen,
   output logic        ctr_ren,
   output logic [16:0] ctr1_wdata,
   output logic [14:0] ctr2_wdata,
   input  logic [16:0] ctr1_rdata,
   input  logic [14:0] ctr2_rdata,
   input  logic        ctr_ready,

   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_RD    = 3'd2,
      S_RWAIT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic              r_owner;      // requester currently being served
   logic              r_last;       // requester served most recently
   logic [31:0]       r_wdata;      // latched write word, drives ctr*_wdata
   logic [31:0]       r_cap;        // captured read word (0 for writes/timeouts)
   logic              r_err;        // captured timeout flag
   logic [TO_W-1:0]   r_to_cnt;

   logic              w_grant_valid;
   logic              w_grant_id;
   logic              w_grant_we;
   logic [31:0]       w_grant_wdata;
   logic [TO_W-1:0]   w_to_cnt_inc;
   logic              w_to_expired;
   logic              w_done;

   // ------------------------------------------------------------------------
   // Arbitration: a lone request wins outright; on a tie the requester that
   // was not served last wins, so continuous contention alternates grants.
   // ------------------------------------------------------------------------
   always_comb begin
      w_grant_valid = req0 | req1;
      w_grant_id    = (req0 & req1) ? ~r_last : req1;
      w_grant_we    = w_grant_id ? we1    : we0;
      w_grant_wdata = w_grant_id ? wdata1 : wdata0;
   end

   // The abort fires on the cycle whose increment would reach TIMEOUT, so a
   // read that never sees ready spends exactly TIMEOUT cycles in RWAIT.
   assign w_to_cnt_inc = r_to_cnt + 1'b1;
   assign w_to_expired = (w_to_cnt_inc == TO_W'(TIMEOUT));

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_valid) begin
               w_state_next = w_grant_we ? S_WR : S_RD;
            end
         end
         S_WR:    w_state_next = S_DONE;
         S_RD:    w_state_next = S_RWAIT;
         S_RWAIT: begin
            if (ctr_ready || w_to_expired) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State register and transaction latches
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_owner  <= 1'b0;
         r_last   <= 1'b1;       // requester 0 wins the first tie
         r_wdata  <= 32'd0;
         r_cap    <= 32'd0;
         r_err    <= 1'b0;
         r_to_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (w_grant_valid) begin
                  r_owner <= w_grant_id;
                  r_wdata <= w_grant_wdata;
                  // Writes report zero data and no error in DONE.
                  r_cap   <= 32'd0;
                  r_err   <= 1'b0;
               end
            end
            S_RD: begin
               r_to_cnt <= '0;
            end
            S_RWAIT: begin
               if (ctr_ready) begin
                  r_cap <= {ctr2_rdata, ctr1_rdata};
                  r_err <= 1'b0;
               end else begin
                  r_to_cnt <= w_to_cnt_inc;
                  if (w_to_expired) begin
                     r_cap <= 32'd0;
                     r_err <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_last <= r_owner;
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: pure decodes of the registered state and latches. ctr*_wdata
   // follow the latched word and therefore hold outside WR.
   // ------------------------------------------------------------------------
   assign busy       = (r_state != S_IDLE);
   assign ctr_wen    = (r_state == S_WR);
   assign ctr_ren    = (r_state == S_RD);
   assign ctr1_wdata = r_wdata[16:0];
   assign ctr2_wdata = r_wdata[31:17];

   assign w_done = (r_state == S_DONE);
   assign ack0   = w_done & ~r_owner;
   assign ack1   = w_done &  r_owner;
   assign err0   = ack0 & r_err;
   assign err1   = ack1 & r_err;
   assign rdata0 = ack0 ? r_cap : 32'd0;
   assign rdata1 = ack1 ? r_cap : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ctr_reg_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctr_reg_arb
// Purpose  : Self-checking bench for ctr_reg_arb. The bench plays both
//            requesters and the register block; a transaction-level model
//            (grant rule, per-transaction length, shadow register contents)
//            predicts every output cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctr_reg_arb;

   localparam int TIMEOUT = 4;
   localparam int TO_W    = 3;

   logic        clk;
   logic        rst;
   logic        req   [2];
   logic        we    [2];
   logic [31:0] wd    [2];
   logic        ack0, ack1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        ctr_wen, ctr_ren, ctr_ready, busy;
   logic [16:0] ctr1_wdata;
   logic [14:0] ctr2_wdata;
   logic [31:0] bus_mem;       // register block contents as written over the bus

   ctr_reg_arb #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req[0]),
      .we0        (we[0]),
      .wdata0     (wd[0]),
      .ack0       (ack0),
      .err0       (err0),
      .rdata0     (rdata0),
      .req1       (req[1]),
      .we1        (we[1]),
      .wdata1     (wd[1]),
      .ack1       (ack1),
      .err1       (err1),
      .rdata1     (rdata1),
      .ctr_wen    (ctr_wen),
      .ctr_ren    (ctr_ren),
      .ctr1_wdata (ctr1_wdata),
      .ctr2_wdata (ctr2_wdata),
      .ctr1_rdata (bus_mem[16:0]),
      .ctr2_rdata (bus_mem[31:17]),
      .ctr_ready  (ctr_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // A granted transaction occupies cycles t=1..L after the grant edge:
   // strobe at t=1, ack at t=L. L = 2 (write), 3 (read), TIMEOUT+2 (timeout).
   bit          m_busy, m_last, m_owner, m_write, m_to, m_rst_prev;
   int          m_t, m_len;
   logic [31:0] m_wdata, m_mem;

   bit          tie_low;       // register block never answers ready
   bit          ren_prev;
   bit          hold_mode, rand_mode;
   int          busy_cnt;
   int          ack_q[$];
   logic [31:0] last_rd [2];

   task automatic model_edge();
      int win;
      if (m_busy && m_write && m_t == 1) m_mem = m_wdata;
      if (rst) begin
         m_busy = 0; m_last = 1; m_owner = 0; m_wdata = 32'd0; m_rst_prev = 1;
      end else begin
         m_rst_prev = 0;
         if (!m_busy) begin
            if (req[0] || req[1]) begin
               if (req[0] && req[1]) win = m_last ? 0 : 1;
               else                  win = req[1] ? 1 : 0;
               m_owner = (win == 1);
               m_write = we[win];
               m_wdata = wd[win];
               m_to    = !m_write && tie_low;
               m_len   = m_write ? 2 : (m_to ? TIMEOUT + 2 : 3);
               m_busy  = 1;
               m_t     = 1;
            end
         end else if (m_t == m_len) begin
            m_busy = 0;
            m_last = m_owner;
         end else begin
            m_t++;
         end
      end
   endtask

   task automatic compare();
      bit          e_ack [2];
      logic [31:0] e_rd  [2];
      bit          e_wen;
      for (int i = 0; i < 2; i++) begin
         e_ack[i] = m_busy && m_t == m_len && (m_owner == (i == 1));
         e_rd[i]  = (e_ack[i] && !m_write && !m_to) ? m_mem : 32'd0;
      end
      e_wen = m_busy && m_write && m_t == 1;
      check("busy",  32'(busy),    32'(m_busy));
      check("wen",   32'(ctr_wen), 32'(e_wen));
      check("ren",   32'(ctr_ren), 32'(m_busy && !m_write && m_t == 1));
      check("ack0",  32'(ack0),    32'(e_ack[0]));
      check("ack1",  32'(ack1),    32'(e_ack[1]));
      check("err0",  32'(err0),    32'(e_ack[0] && m_to));
      check("err1",  32'(err1),    32'(e_ack[1] && m_to));
      check("rdata0", rdata0, e_rd[0]);
      check("rdata1", rdata1, e_rd[1]);
      if (e_wen || m_rst_prev)
         check("ctr_wdata", {ctr2_wdata, ctr1_wdata}, e_wen ? m_wdata : 32'd0);
   endtask

   // Register block: writes land at the edge that samples ctr_wen; ready is
   // answered in the cycle after ctr_ren unless tied low.
   task automatic bus_respond();
      if (ctr_wen) bus_mem = {ctr2_wdata, ctr1_wdata};
      ctr_ready = ren_prev && !tie_low;
      ren_prev  = ctr_ren;
   endtask

   task automatic req_update();
      bit a [2];
      a[0] = ack0;
      a[1] = ack1;
      for (int i = 0; i < 2; i++) begin
         if (a[i]) begin
            req[i] = 1'b0;
         end else if (!req[i] && !(m_busy && m_owner == (i == 1))) begin
            if (hold_mode) begin
               req[i] = 1'b1; we[i] = 1'b0;
            end else if (rand_mode && $urandom % 4 == 0) begin
               req[i] = 1'b1; we[i] = $urandom % 2 == 1; wd[i] = $urandom;
            end
         end else if (req[i] && rand_mode && m_busy && m_owner == (i == 1) && $urandom % 16 == 0) begin
            req[i] = 1'b0;   // mid-transaction drop; the ack must still come
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare();
      bus_respond();
      if (busy) busy_cnt++;
      if (ack0) begin ack_q.push_back(0); last_rd[0] = rdata0; end
      if (ack1) begin ack_q.push_back(1); last_rd[1] = rdata1; end
      req_update();
   endtask

   task automatic run_until_quiet(input int max_cycles);
      int n;
      n = 0;
      step();
      while ((m_busy || req[0] || req[1]) && n < max_cycles) begin
         step();
         n++;
      end
      if (m_busy || req[0] || req[1]) check("quiet_timeout", 32'd1, 32'd0);
   endtask

   task automatic issue(input int i, input bit w, input logic [31:0] d);
      req[i] = 1'b1; we[i] = w; wd[i] = d;
   endtask

   initial begin
      rst = 1'b1; ctr_ready = 1'b0; bus_mem = 32'd0;
      for (int i = 0; i < 2; i++) begin req[i] = 0; we[i] = 0; wd[i] = 0; last_rd[i] = 0; end
      m_busy = 0; m_last = 1; m_owner = 0; m_write = 0; m_to = 0; m_rst_prev = 0;
      m_t = 0; m_len = 0; m_wdata = 0; m_mem = 0;
      tie_low = 0; ren_prev = 0; hold_mode = 0; rand_mode = 0; busy_cnt = 0;

      // reset state
      step(); step();
      rst = 1'b0;

      // write from requester 0, then read it back through requester 1
      issue(0, 1'b1, 32'hABCD_1234);
      run_until_quiet(20);
      check("p1_bus_word", bus_mem, 32'hABCD_1234);
      issue(1, 1'b0, 32'd0);
      run_until_quiet(20);
      check("p2_rdata1", last_rd[1], 32'hABCD_1234);

      // both requesters reading continuously from reset
      rst = 1'b1; issue(0, 1'b0, 32'd0); issue(1, 1'b0, 32'd0);
      step();
      rst = 1'b0; hold_mode = 1; ack_q.delete();
      repeat (16) step();
      hold_mode = 0;
      run_until_quiet(20);
      check("p3_grants", 32'(ack_q.size() >= 4), 32'd1);
      for (int k = 0; k < 4 && k < ack_q.size(); k++)
         check("p3_grant_order", 32'(ack_q[k]), 32'(k % 2));

      // read timeout with ready tied low
      tie_low = 1; busy_cnt = 0;
      issue(0, 1'b0, 32'd0);
      run_until_quiet(30);
      check("p4_busy_len", 32'(busy_cnt), 32'(TIMEOUT + 2));
      check("p4_rdata0", last_rd[0], 32'd0);

      // reset during RWAIT; last was 0, but reset makes requester 0 win
      issue(0, 1'b0, 32'd0);
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0; tie_low = 0; ack_q.delete();
      issue(1, 1'b0, 32'd0);
      run_until_quiet(30);
      check("p5_first_owner", 32'((ack_q.size() > 0) ? ack_q[0] : 9), 32'd0);

      // packing check via write-then-read from one requester
      issue(0, 1'b1, 32'h0001_FFFF);
      run_until_quiet(20);
      issue(0, 1'b0, 32'd0);
      run_until_quiet(20);
      check("p6_rdata0", last_rd[0], 32'h0001_FFFF);

      // randomized traffic with occasional resets and unresponsive reads
      rand_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom % 150 == 0);
         if (!m_busy && $urandom % 40 == 0) tie_low = !tie_low;
         step();
      end
      rst = 1'b0; rand_mode = 0; tie_low = 0;
      run_until_quiet(100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
